obi_arbiter: RTL and testbench
==============================

# obi_arbiter

Two-host to one-device OBI arbiter that shares the single external memory port between the instruction-fetch host (host 0) and the load/store host (host 1). It sits between the two host drivers and the memory device. It accepts one address phase at a time, routes the response back to the host that owns the outstanding transaction, and uses round-robin priority so neither host can starve the other. At most one transaction is outstanding, matching the host drivers.

## Interface
Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width; byte-enable width is DATA_W/8

Ports (host ports shown for host x, x = 0 or 1; each host has its own set):
- clk_i  in  1  clock; all state updates on rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- hx_req_i  in  1  host x address-phase request
- hx_addr_i  in  ADDR_W  host x address
- hx_we_i  in  1  host x write enable
- hx_be_i  in  DATA_W/8  host x byte enables
- hx_wdata_i  in  DATA_W  host x write data
- hx_gnt_o  out  1  grant to host x
- hx_rvalid_o  out  1  response valid to host x
- hx_rdata_o  out  DATA_W  read data to host x; carries dev_rdata_i to both hosts
- dev_req_o  out  1  request to device
- dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o  out  ADDR_W/1/DATA_W/8/DATA_W  muxed address-phase signals
- dev_gnt_i  in  1  device grant
- dev_rvalid_i  in  1  device response valid
- dev_rdata_i  in  DATA_W  device read data

## Operation
- State register PS has three states:
  - IDLE: no transaction outstanding.
  - RESP0: response owed to host 0.
  - RESP1: response owed to host 1.
- Priority register `last` holds the most recently granted host. The other host wins ties.
- Reset values:
  - PS = IDLE; last = 0, so host 1 (data) wins the first tie.
  - All outputs are combinational. With rst_ni low, dev_req_o, h0_gnt_o, h1_gnt_o, h0_rvalid_o and h1_rvalid_o are all 0.
- Selection (`sel`) in IDLE, combinational:
  - Only one host requesting: `sel` is that host.
  - Both requesting: `sel` is ~last.
  - Neither requesting: dev_req_o = 0, `sel` = ~last, dev_* carry the `sel` host's signals.
- IDLE outputs:
  - dev_req_o = h0_req_i | h1_req_i.
  - dev_addr_o, dev_we_o, dev_be_o and dev_wdata_o carry the `sel` host's signals.
  - hsel_gnt_o = dev_gnt_i & hsel_req_i; the other host's gnt is 0.
- IDLE transition: on dev_req_o & dev_gnt_i, PS moves to RESP<sel> and last <= sel. Otherwise PS stays IDLE and last is unchanged.
- RESP states:
  - dev_req_o = 0 and both gnt outputs are 0; no new address phase is issued.
  - hx_rvalid_o = dev_rvalid_i only for the owning host; the other host's rvalid is 0.
- RESP transition: on dev_rvalid_i, PS moves to IDLE, so the next address phase can be granted one cycle after rvalid.
- dev_rvalid_i in IDLE (stale response) is dropped: both rvalid outputs are 0.
- An illegal PS value decodes as IDLE, with next state IDLE.

## Timing
- Arbitration adds no latency: a request and grant in IDLE complete in the same cycle as the host request.
- Minimum spacing between successive grants is 2 cycles: grant in cycle n, rvalid in cycle n+1 at the earliest, next grant in cycle n+2.
- The host owning the pending request must hold its request stable until granted (OBI rule). The arbiter registers nothing from the address phase except owner and last.
- Simultaneous events:
  - Both hosts request in the same cycle as the grant: only the `sel` host sees gnt. The loser keeps req high and wins the next IDLE arbitration.
  - dev_rvalid_i and a new host request in the same cycle: the request waits until IDLE, one cycle later.
- Reset asserted mid-transaction: PS goes to IDLE immediately. A late device rvalid is then dropped per the IDLE rule.

## Test plan
- Reset: hold rst_ni = 0 with both req = 1 and dev_gnt_i = 1 -> dev_req_o = 0 and all gnt/rvalid = 0. Release reset -> h1 is granted first, with dev_addr_o = h1_addr_i.
- Single host: h0 requests addr 0x1000 with grant at cycle 0 and rvalid at cycle 2 -> h0_gnt_o is 1 at cycle 0 only; h0_rvalid_o is 1 at cycle 2, h1_rvalid_o stays 0; dev_req_o is 0 in cycles 1–2.
- Contention: both hosts request continuously with gnt = 1 and rvalid one cycle after each grant -> grants alternate h1, h0, h1, h0 at cycles 0, 2, 4, 6.
- Write routing: h1 writes we = 1, be = 0xFF, wdata = 0xDEADBEEF → device sees those values; the following rvalid goes to h1 only.
- Stall: device holds gnt = 0 for 3 cycles with h0 requesting -> h0_gnt_o stays 0 and dev_addr_o is stable. h1 asserting a request in cycle 2 does not preempt h0 mid-wait.
- Reset mid-RESP0 with a device rvalid arriving after reset release -> both rvalid outputs are 0, and PS is IDLE with the next request granted normally.

Source files
------------

// File: rtl/obi_arbiter.sv
// -----------------------------------------------------------------------------
// obi_arbiter
//
// Shares one OBI device port between two hosts: host 0 (instruction fetch) and
// host 1 (load/store). One address phase is accepted at a time and at most one
// transaction is outstanding. The response is steered back to the host that
// owns the outstanding transaction. Round-robin priority (the host not granted
// most recently wins a tie) keeps either host from starving the other.
//
// Ports
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   hX_req_i / hX_addr_i / hX_we_i    host X address phase (X = 0, 1)
//   hX_be_i / hX_wdata_i
//   hX_gnt_o                          grant to host X
//   hX_rvalid_o / hX_rdata_o          response to host X (rdata shared)
//   dev_req_o / dev_addr_o / ...      muxed address phase to the device
//   dev_gnt_i                         device grant
//   dev_rvalid_i / dev_rdata_i        device response
//
// All outputs are combinational. The only state is the transaction owner
// (encoded in the state register) and the last granted host.
// -----------------------------------------------------------------------------
module obi_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,

  input  logic                h0_req_i,
  input  logic [ADDR_W-1:0]   h0_addr_i,
  input  logic                h0_we_i,
  input  logic [DATA_W/8-1:0] h0_be_i,
  input  logic [DATA_W-1:0]   h0_wdata_i,
  output logic                h0_gnt_o,
  output logic                h0_rvalid_o,
  output logic [DATA_W-1:0]   h0_rdata_o,

  input  logic                h1_req_i,
  input  logic [ADDR_W-1:0]   h1_addr_i,
  input  logic                h1_we_i,
  input  logic [DATA_W/8-1:0] h1_be_i,
  input  logic [DATA_W-1:0]   h1_wdata_i,
  output logic                h1_gnt_o,
  output logic                h1_rvalid_o,
  output logic [DATA_W-1:0]   h1_rdata_o,

  output logic                dev_req_o,
  output logic [ADDR_W-1:0]   dev_addr_o,
  output logic                dev_we_o,
  output logic [DATA_W/8-1:0] dev_be_o,
  output logic [DATA_W-1:0]   dev_wdata_o,
  input  logic                dev_gnt_i,
  input  logic                dev_rvalid_i,
  input  logic [DATA_W-1:0]   dev_rdata_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESP0 = 2'd1,
    RESP1 = 2'd2
  } state_t;

  state_t ps;
  logic   last;   // most recently granted host
  logic   sel;    // host chosen for the current address phase
  logic   resp0;
  logic   resp1;
  logic   idle;

  // Host selection: a lone requester wins outright; on a tie (or with no
  // requester at all) the host that was not granted last is selected.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    sel = ~last;
    if (h0_req_i && !h1_req_i) begin
      sel = 1'b0;
    end else if (h1_req_i && !h0_req_i) begin
      sel = 1'b1;
    end
  end

  // The unused encoding falls through to idle behaviour.
  assign resp0 = (ps == RESP0);
  assign resp1 = (ps == RESP1);
  assign idle  = !resp0 && !resp1;

  // NOTE: outputs are combinational from inputs, so they are qualified with
  // rst_ni directly; the state register alone cannot silence dev_req_o or the
  // grants while reset is held with hosts requesting.
  assign dev_req_o   = rst_ni & idle & (h0_req_i | h1_req_i);
  assign h0_gnt_o    = rst_ni & idle & ~sel & h0_req_i & dev_gnt_i;
  assign h1_gnt_o    = rst_ni & idle &  sel & h1_req_i & dev_gnt_i;

  // Responses reach only the owning host; a response in idle is stale and
  // dropped.
  assign h0_rvalid_o = rst_ni & resp0 & dev_rvalid_i;
  assign h1_rvalid_o = rst_ni & resp1 & dev_rvalid_i;
  assign h0_rdata_o  = dev_rdata_i;
  assign h1_rdata_o  = dev_rdata_i;

  assign dev_addr_o  = sel ? h1_addr_i  : h0_addr_i;
  assign dev_we_o    = sel ? h1_we_i    : h0_we_i;
  assign dev_be_o    = sel ? h1_be_i    : h0_be_i;
  assign dev_wdata_o = sel ? h1_wdata_i : h0_wdata_i;

  // Owner / priority tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ps   <= IDLE;
      last <= 1'b0;   // host 1 wins the first tie
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      case (ps)
        IDLE: begin
          if (dev_req_o && dev_gnt_i) begin
            ps   <= sel ? RESP1 : RESP0;
            last <= sel;
          end
        end
        RESP0, RESP1: begin
          if (dev_rvalid_i) begin
            ps <= IDLE;
          end
        end
        default: ps <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_obi_arbiter
//
// Directed scenarios (reset, single host, contention, write routing, stall,
// reset mid-response) followed by a randomized run checked against a
// transaction-level model: the model keeps the owner of the outstanding
// transaction (or none) and the last granted host, and predicts every cycle's
// grant/response outputs from the arbitration rules.
// -----------------------------------------------------------------------------
module tb_obi_arbiter;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned BE_W   = DATA_W / 8;

  logic              clk_i;
  logic              rst_ni;
  logic              h0_req_i,   h1_req_i;
  logic [ADDR_W-1:0] h0_addr_i,  h1_addr_i;
  logic              h0_we_i,    h1_we_i;
  logic [BE_W-1:0]   h0_be_i,    h1_be_i;
  logic [DATA_W-1:0] h0_wdata_i, h1_wdata_i;
  logic              h0_gnt_o,   h1_gnt_o;
  logic              h0_rvalid_o, h1_rvalid_o;
  logic [DATA_W-1:0] h0_rdata_o, h1_rdata_o;
  logic              dev_req_o;
  logic [ADDR_W-1:0] dev_addr_o;
  logic              dev_we_o;
  logic [BE_W-1:0]   dev_be_o;
  logic [DATA_W-1:0] dev_wdata_o;
  logic              dev_gnt_i;
  logic              dev_rvalid_i;
  logic [DATA_W-1:0] dev_rdata_i;

  int checks = 0;
  int errors = 0;

  obi_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .h0_req_i    (h0_req_i),
    .h0_addr_i   (h0_addr_i),
    .h0_we_i     (h0_we_i),
    .h0_be_i     (h0_be_i),
    .h0_wdata_i  (h0_wdata_i),
    .h0_gnt_o    (h0_gnt_o),
    .h0_rvalid_o (h0_rvalid_o),
    .h0_rdata_o  (h0_rdata_o),
    .h1_req_i    (h1_req_i),
    .h1_addr_i   (h1_addr_i),
    .h1_we_i     (h1_we_i),
    .h1_be_i     (h1_be_i),
    .h1_wdata_i  (h1_wdata_i),
    .h1_gnt_o    (h1_gnt_o),
    .h1_rvalid_o (h1_rvalid_o),
    .h1_rdata_o  (h1_rdata_o),
    .dev_req_o   (dev_req_o),
    .dev_addr_o  (dev_addr_o),
    .dev_we_o    (dev_we_o),
    .dev_be_o    (dev_be_o),
    .dev_wdata_o (dev_wdata_o),
    .dev_gnt_i   (dev_gnt_i),
    .dev_rvalid_i(dev_rvalid_i),
    .dev_rdata_i (dev_rdata_i)
  );

  // {dev_req, h0_gnt, h1_gnt, h0_rvalid, h1_rvalid}
  logic [4:0]   ctl;
  logic [136:0] dev_ap;
  assign ctl    = {dev_req_o, h0_gnt_o, h1_gnt_o, h0_rvalid_o, h1_rvalid_o};
  assign dev_ap = {dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o};

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Inputs change 1 time unit after the rising edge; outputs are sampled on
  // the falling edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    h0_req_i = 1'b0; h1_req_i = 1'b0;
    dev_gnt_i = 1'b0; dev_rvalid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    h0_req_i = 1'b1; h0_addr_i = 64'h0000_0000_0000_0A00;
    h1_req_i = 1'b1; h1_addr_i = 64'h0000_0000_0000_0B00;
    dev_gnt_i = 1'b1; dev_rvalid_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (ctl !== 5'b00000) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b", ctl, 5'b00000);
    end
    tick();
    rst_ni = 1'b1; dev_rvalid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (ctl !== 5'b10100 || dev_addr_o !== 64'h0B00) begin
      errors++; $display("FAIL reset_first_grant: got ctl %b addr %h expected ctl %b addr %h",
                         ctl, dev_addr_o, 5'b10100, 64'h0B00);
    end
    tick();
    h0_req_i = 1'b0; h1_req_i = 1'b0; dev_gnt_i = 1'b0; dev_rvalid_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (ctl !== 5'b00001) begin
      errors++; $display("FAIL reset_first_resp: got %b expected %b", ctl, 5'b00001);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_single_host();
    do_reset();
    h0_req_i = 1'b1; h0_addr_i = 64'h1000; dev_gnt_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (ctl !== 5'b11000 || dev_addr_o !== 64'h1000) begin
      errors++; $display("FAIL single_c0: got ctl %b addr %h expected ctl %b addr %h",
                         ctl, dev_addr_o, 5'b11000, 64'h1000);
    end
    tick();  // cycle 1: request and device grant still high, but response pending
    @(negedge clk_i);
    checks++;
    if (ctl !== 5'b00000) begin
      errors++; $display("FAIL single_c1: got %b expected %b", ctl, 5'b00000);
    end
    tick();  // cycle 2: response
    dev_rvalid_i = 1'b1; dev_rdata_i = 64'hCAFE_F00D_1234_5678;
    @(negedge clk_i);
    checks++;
    if (ctl !== 5'b00010 || h0_rdata_o !== 64'hCAFE_F00D_1234_5678) begin
      errors++; $display("FAIL single_c2: got ctl %b rdata %h expected ctl %b rdata %h",
                         ctl, h0_rdata_o, 5'b00010, 64'hCAFE_F00D_1234_5678);
    end
    tick();
    idle_inputs();
    @(negedge clk_i);
    checks++;
    if (ctl !== 5'b00000) begin
      errors++; $display("FAIL single_c3: got %b expected %b", ctl, 5'b00000);
    end
    tick();
  endtask

  task automatic test_contention();
    int prev;
    int host;
    logic [4:0] exp;
    logic [ADDR_W-1:0] exp_addr;
    do_reset();
    prev = 0;
    h0_req_i = 1'b1; h0_addr_i = 64'h00A0;
    h1_req_i = 1'b1; h1_addr_i = 64'h00B0;
    dev_gnt_i = 1'b1; dev_rvalid_i = 1'b1;  // rvalid in idle cycles must be dropped
    for (int c = 0; c < 8; c++) begin
      if (c % 2 == 0) begin
        host = ((c / 2) % 2 == 0) ? 1 : 0;
        exp = {1'b1, host == 0, host == 1, 2'b00};
        exp_addr = (host == 1) ? 64'h00B0 : 64'h00A0;
        prev = host;
      end else begin
        exp = {3'b000, prev == 0, prev == 1};
        exp_addr = dev_addr_o;
      end
      @(negedge clk_i);
      checks++;
      if (ctl !== exp || (c % 2 == 0 && dev_addr_o !== exp_addr)) begin
        errors++; $display("FAIL contention_c%0d: got ctl %b addr %h expected ctl %b addr %h",
                           c, ctl, dev_addr_o, exp, exp_addr);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_write_routing();
    logic [136:0] exp_ap;
    do_reset();
    h0_addr_i = 64'h7777; h0_we_i = 1'b0; h0_be_i = 8'h01; h0_wdata_i = 64'h1111;
    h1_req_i = 1'b1; h1_addr_i = 64'h5000; h1_we_i = 1'b1; h1_be_i = 8'hFF;
    h1_wdata_i = 64'hDEADBEEF; dev_gnt_i = 1'b1;
    exp_ap = {64'h5000, 1'b1, 8'hFF, 64'hDEADBEEF};
    @(negedge clk_i);
    checks++;
    if (dev_ap !== exp_ap || ctl !== 5'b10100) begin
      errors++; $display("FAIL write_ap: got %h ctl %b expected %h ctl %b",
                         dev_ap, ctl, exp_ap, 5'b10100);
    end
    tick();
    h1_req_i = 1'b0; dev_gnt_i = 1'b0; dev_rvalid_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (ctl !== 5'b00001) begin
      errors++; $display("FAIL write_resp: got %b expected %b", ctl, 5'b00001);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    // Host 1 transaction first, so host 0 holds priority afterwards.
    h1_req_i = 1'b1; h1_addr_i = 64'h2000; dev_gnt_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (ctl !== 5'b10100) begin
      errors++; $display("FAIL stall_setup: got %b expected %b", ctl, 5'b10100);
    end
    tick();
    h1_req_i = 1'b0; dev_gnt_i = 1'b0; dev_rvalid_i = 1'b1;
    tick();
    dev_rvalid_i = 1'b0;
    h0_req_i = 1'b1; h0_addr_i = 64'h3000;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        h1_req_i = 1'b1; h1_addr_i = 64'h4000;
      end
      @(negedge clk_i);
      checks++;
      if (ctl !== 5'b10000 || dev_addr_o !== 64'h3000) begin
        errors++; $display("FAIL stall_wait_c%0d: got ctl %b addr %h expected ctl %b addr %h",
                           c, ctl, dev_addr_o, 5'b10000, 64'h3000);
      end
      tick();
    end
    dev_gnt_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (ctl !== 5'b11000 || dev_addr_o !== 64'h3000) begin
      errors++; $display("FAIL stall_grant: got ctl %b addr %h expected ctl %b addr %h",
                         ctl, dev_addr_o, 5'b11000, 64'h3000);
    end
    tick();
    h0_req_i = 1'b0; dev_rvalid_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (ctl !== 5'b00010) begin
      errors++; $display("FAIL stall_resp: got %b expected %b", ctl, 5'b00010);
    end
    tick();
    dev_rvalid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (ctl !== 5'b10100 || dev_addr_o !== 64'h4000) begin
      errors++; $display("FAIL stall_loser_next: got ctl %b addr %h expected ctl %b addr %h",
                         ctl, dev_addr_o, 5'b10100, 64'h4000);
    end
    tick();
    h1_req_i = 1'b0; dev_gnt_i = 1'b0; dev_rvalid_i = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_resp();
    do_reset();
    h0_req_i = 1'b1; h0_addr_i = 64'h6000; dev_gnt_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (ctl !== 5'b11000) begin
      errors++; $display("FAIL midrst_grant: got %b expected %b", ctl, 5'b11000);
    end
    tick();  // now owing host 0 a response
    h0_req_i = 1'b0; dev_gnt_i = 1'b0; rst_ni = 1'b0;
    @(negedge clk_i);
    tick();
    rst_ni = 1'b1; dev_rvalid_i = 1'b1;  // late response after reset release
    @(negedge clk_i);
    checks++;
    if (ctl !== 5'b00000) begin
      errors++; $display("FAIL midrst_stale: got %b expected %b", ctl, 5'b00000);
    end
    tick();
    dev_rvalid_i = 1'b0;
    h0_req_i = 1'b1; h1_req_i = 1'b1; h1_addr_i = 64'h6100; dev_gnt_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (ctl !== 5'b10100 || dev_addr_o !== 64'h6100) begin
      errors++; $display("FAIL midrst_regrant: got ctl %b addr %h expected ctl %b addr %h",
                         ctl, dev_addr_o, 5'b10100, 64'h6100);
    end
    tick();
    idle_inputs();
    dev_rvalid_i = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    int m_owner;   // -1: nothing outstanding, else owning host
    int m_last;
    int win;
    bit any;
    logic [4:0]   exp;
    logic [136:0] exp_ap;
    do_reset();
    m_owner = -1;
    m_last  = 0;
    for (int i = 0; i < 600; i++) begin
      if (i % 101 == 60) begin
        rst_ni = 1'b0;
        @(negedge clk_i);
        checks++;
        if (ctl !== 5'b00000) begin
          errors++; $display("FAIL rand_reset_i%0d: got %b expected %b", i, ctl, 5'b00000);
        end
        tick();
        rst_ni  = 1'b1;
        m_owner = -1;
        m_last  = 0;
      end
      // Hosts raise a request at random and hold it until granted.
      if (!h0_req_i && $urandom_range(0, 2) == 0) begin
        h0_req_i = 1'b1; h0_addr_i = {$urandom, $urandom}; h0_we_i = 1'($urandom);
        h0_be_i = 8'($urandom); h0_wdata_i = {$urandom, $urandom};
      end
      if (!h1_req_i && $urandom_range(0, 2) == 0) begin
        h1_req_i = 1'b1; h1_addr_i = {$urandom, $urandom}; h1_we_i = 1'($urandom);
        h1_be_i = 8'($urandom); h1_wdata_i = {$urandom, $urandom};
      end
      dev_gnt_i    = ($urandom_range(0, 3) != 0);
      dev_rvalid_i = 1'($urandom_range(0, 1));
      dev_rdata_i  = {$urandom, $urandom};

      any = h0_req_i | h1_req_i;
      if (h0_req_i && !h1_req_i)      win = 0;
      else if (h1_req_i && !h0_req_i) win = 1;
      else                            win = 1 - m_last;
      if (m_owner < 0)
        exp = {any, (win == 0) && h0_req_i && dev_gnt_i,
               (win == 1) && h1_req_i && dev_gnt_i, 2'b00};
      else
        exp = {3'b000, (m_owner == 0) && dev_rvalid_i, (m_owner == 1) && dev_rvalid_i};
      exp_ap = (win == 0) ? {h0_addr_i, h0_we_i, h0_be_i, h0_wdata_i}
                          : {h1_addr_i, h1_we_i, h1_be_i, h1_wdata_i};

      @(negedge clk_i);
      checks++;
      if (ctl !== exp) begin
        errors++; $display("FAIL rand_ctl_i%0d: got %b expected %b", i, ctl, exp);
      end
      if (m_owner < 0 && any) begin
        checks++;
        if (dev_ap !== exp_ap) begin
          errors++; $display("FAIL rand_ap_i%0d: got %h expected %h", i, dev_ap, exp_ap);
        end
      end
      checks++;
      if (h0_rdata_o !== dev_rdata_i || h1_rdata_o !== dev_rdata_i) begin
        errors++; $display("FAIL rand_rdata_i%0d: got %h/%h expected %h",
                           i, h0_rdata_o, h1_rdata_o, dev_rdata_i);
      end
      tick();

      // Advance the model with the values present at the edge.
      if (m_owner < 0) begin
        if (any && dev_gnt_i) begin
          m_owner = win;
          m_last  = win;
          if (win == 0) h0_req_i = 1'b0;
          else          h1_req_i = 1'b0;
        end
      end else if (dev_rvalid_i) begin
        m_owner = -1;
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst_ni = 1'b0;
    h0_addr_i = '0; h0_we_i = 1'b0; h0_be_i = '0; h0_wdata_i = '0;
    h1_addr_i = '0; h1_we_i = 1'b0; h1_be_i = '0; h1_wdata_i = '0;
    dev_rdata_i = '0;
    idle_inputs();
    tick();
    test_reset();
    test_single_host();
    test_contention();
    test_write_routing();
    test_stall();
    test_reset_mid_resp();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
